wb_copy_master: RTL and testbench

Wishbone classic bus master that copies a block of 32-bit words from a source word address to a destination word address, one read followed by one write per word. It is the initiator counterpart of the SoC's Wishbone slaves (boot ROM, data RAM, peripherals). It sits on the SoC bus as an additional master, typically used to copy boot images from ROM into RAM before the core is released. It provides start/busy/done/error control, a per-access timeout, and abort on bus error.

---
 rtl/wb_copy_master.sv | 135 +++++++++++++
 tb/tb_wb_copy_master.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_copy_master.sv
// Wishbone classic master that copies a block of 32-bit words, one read then one write per word.
// Start/busy/done/error control with per-access timeout and abort on slave error.
module wb_copy_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [29:0] src_i,
    input  logic [29:0] dst_i,
    input  logic [15:0] len_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [29:0] adr_o,
    output logic [3:0]  sel_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    input  logic        err_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE
    } state_e;

    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

    state_e      state_q, state_d;
    logic [29:0] src_q, src_d;
    logic [29:0] dst_q, dst_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] wait_q, wait_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            wait_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            wait_q  <= wait_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // err_i beats ack_i; ack_i beats an expiring timeout on the same edge.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        wait_d  = wait_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    src_d   = src_i;
                    dst_d   = dst_i;
                    rem_d   = len_i;
                    wait_d  = '0;
                    err_d   = 1'b0;
                    state_d = (len_i == 16'd0) ? S_DONE : S_RD;
                end
            end
            S_RD: begin
                if (err_i) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (ack_i) begin
                    data_d  = dat_i;
                    wait_d  = '0;
                    state_d = S_WR;
                end else if (wait_q == TIMEOUT_W) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            S_WR: begin
                if (err_i) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (ack_i) begin
                    src_d   = src_q + 30'd1;
                    dst_d   = dst_q + 30'd1;
                    rem_d   = rem_q - 16'd1;
                    wait_d  = '0;
                    state_d = (rem_q == 16'd1) ? S_DONE : S_RD;
                end else if (wait_q == TIMEOUT_W) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus controls decode from state alone so reset clears them without a clock edge.
    assign busy_o = (state_q == S_RD) || (state_q == S_WR);
    assign cyc_o  = busy_o;
    assign stb_o  = busy_o;
    assign we_o   = (state_q == S_WR);
    assign done_o = (state_q == S_DONE);
    assign err_o  = err_q;
    assign adr_o  = (state_q == S_WR) ? dst_q : src_q;
    assign sel_o  = 4'hF;
    assign dat_o  = data_q;

endmodule

// File: tb/tb_wb_copy_master.sv
// Scoreboard bench for wb_copy_master: a configurable Wishbone slave with memory,
// expected bus events queued by the directed tests and popped by an independent monitor.
module tb_wb_copy_master;

    localparam int TO = 8;

    logic        clk;
    logic        rst_ni;
    logic        start_i;
    logic [29:0] src_i;
    logic [29:0] dst_i;
    logic [15:0] len_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [29:0] adr_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        ack_i;
    logic        err_i;

    wb_copy_master #(.TIMEOUT(TO)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .start_i(start_i),
        .src_i  (src_i),
        .dst_i  (dst_i),
        .len_i  (len_i),
        .busy_o (busy_o),
        .done_o (done_o),
        .err_o  (err_o),
        .cyc_o  (cyc_o),
        .stb_o  (stb_o),
        .we_o   (we_o),
        .adr_o  (adr_o),
        .sel_o  (sel_o),
        .dat_o  (dat_o),
        .dat_i  (dat_i),
        .ack_i  (ack_i),
        .err_i  (err_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 = read, 1 = write, 2 = done pulse; flag = err termination / err_o at done
    typedef struct {
        int          kind;
        logic [29:0] adr;
        logic [31:0] dat;
        logic        flag;
    } ev_t;

    ev_t  exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   stb_cnt = 0;
    int   done_cnt = 0;
    int   nrd = 0;
    int   nwr = 0;
    int   wait_cyc = 1;
    bit   no_ack = 1'b0;
    int   err_wr_idx = 0;
    int   sw = 0;
    logic [31:0] mem [logic [29:0]];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic exp_rd(input logic [29:0] a);
        ev_t e;
        e.kind = 0; e.adr = a; e.dat = '0; e.flag = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic exp_wr(input logic [29:0] a, input logic [31:0] d, input logic f);
        ev_t e;
        e.kind = 1; e.adr = a; e.dat = d; e.flag = f;
        exp_q.push_back(e);
    endtask

    task automatic exp_done(input logic f);
        ev_t e;
        e.kind = 2; e.adr = '0; e.dat = '0; e.flag = f;
        exp_q.push_back(e);
    endtask

    task automatic start_xfer(input logic [29:0] s, input logic [29:0] d, input logic [15:0] l);
        @(negedge clk);
        start_i = 1'b1; src_i = s; dst_i = d; len_i = l;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cyc);
        bit got = 1'b0;
        for (int i = 0; i < max_cyc && !got; i++) begin
            #2;
            if (done_o) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) chk(name, 64'd0, 64'd1);
    endtask

    // Slave: ack/err presented at negedge, sampled by the DUT on the next posedge.
    initial begin
        ack_i = 1'b0; err_i = 1'b0; dat_i = '0;
        forever begin
            @(negedge clk);
            if (!cyc_o) begin
                ack_i = 1'b0; err_i = 1'b0; sw = 0;
            end else begin
                if (ack_i || err_i) sw = 0;
                ack_i = 1'b0; err_i = 1'b0;
                if (!no_ack && sw >= wait_cyc) begin
                    if (we_o) begin
                        nwr++;
                        if (nwr == err_wr_idx) err_i = 1'b1;
                        else begin
                            ack_i = 1'b1;
                            mem[adr_o] = dat_o;
                        end
                    end else begin
                        nrd++;
                        dat_i = mem.exists(adr_o) ? mem[adr_o] : 32'h0;
                        ack_i = 1'b1;
                    end
                end else begin
                    sw++;
                end
            end
        end
    end

    // Monitor: pops one expected event per bus completion or done pulse.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_ni) begin
                if (cyc_o && stb_o) stb_cnt++;
                if (cyc_o && (ack_i || err_i)) begin
                    if (exp_q.size() == 0) chk("sb_underflow_access", 64'd1, 64'd0);
                    else begin
                        e = exp_q.pop_front();
                        chk("sb_kind", we_o ? 64'd1 : 64'd0, 64'(e.kind));
                        chk("sb_adr", 64'(adr_o), 64'(e.adr));
                        if (we_o) chk("sb_wdat", 64'(dat_o), 64'(e.dat));
                        chk("sb_term_err", 64'(err_i), 64'(e.flag));
                    end
                end
                if (done_o) begin
                    done_cnt++;
                    if (exp_q.size() == 0) chk("sb_underflow_done", 64'd1, 64'd0);
                    else begin
                        e = exp_q.pop_front();
                        chk("sb_kind", 64'd2, 64'(e.kind));
                        chk("done_err", 64'(err_o), 64'(e.flag));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d0, d1;
        int rd_base;
        rst_ni = 1'b1; start_i = 1'b0; src_i = '0; dst_i = '0; len_i = '0;
        #1 rst_ni = 1'b0;
        #2;
        chk("rst_cyc", 64'(cyc_o), 64'd0);
        chk("rst_stb", 64'(stb_o), 64'd0);
        chk("rst_we", 64'(we_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_adr", 64'(adr_o), 64'd0);
        chk("rst_dat", 64'(dat_o), 64'd0);
        chk("rst_sel", 64'(sel_o), 64'hF);
        @(negedge clk); @(negedge clk);
        rst_ni = 1'b1;

        // Copy four words with a one-wait slave
        mem[30'h0] = 32'h11111111; mem[30'h1] = 32'h22222222;
        mem[30'h2] = 32'h33333333; mem[30'h3] = 32'h44444444;
        wait_cyc = 1; stb_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            exp_rd(30'(i));
            exp_wr(30'h400 + 30'(i), 32'h11111111 * (i + 1), 1'b0);
        end
        exp_done(1'b0);
        start_xfer(30'h0, 30'h400, 16'd4);
        wait_done("copy_done_timeout", 100);
        @(negedge clk); #2;
        chk("copy_ram0", 64'(mem[30'h400]), 64'h11111111);
        chk("copy_ram1", 64'(mem[30'h401]), 64'h22222222);
        chk("copy_ram2", 64'(mem[30'h402]), 64'h33333333);
        chk("copy_ram3", 64'(mem[30'h403]), 64'h44444444);
        chk("copy_stb_cycles", 64'(stb_cnt), 64'd16);
        chk("copy_done_pulses", 64'(done_cnt), 64'd1);
        chk("copy_err", 64'(err_o), 64'd0);
        chk("copy_sb_empty", 64'(exp_q.size()), 64'd0);

        // len = 0
        stb_cnt = 0; done_cnt = 0;
        exp_done(1'b0);
        start_xfer(30'h5, 30'h6, 16'd0);
        #2;
        chk("len0_done", 64'(done_o), 64'd1);
        chk("len0_busy", 64'(busy_o), 64'd0);
        @(negedge clk); #2;
        chk("len0_done_one_cycle", 64'(done_o), 64'd0);
        chk("len0_no_cyc", 64'(stb_cnt), 64'd0);
        chk("len0_done_pulses", 64'(done_cnt), 64'd1);

        // Error abort on second write
        d0 = 32'hA0A00001; d1 = 32'hA0A00002;
        mem[30'h10] = d0; mem[30'h11] = d1; mem[30'h12] = 32'hA0A00003;
        mem[30'h501] = 32'hDEADBEEF;
        wait_cyc = 0; err_wr_idx = nwr + 2; rd_base = nrd;
        exp_rd(30'h10); exp_wr(30'h500, d0, 1'b0);
        exp_rd(30'h11); exp_wr(30'h501, d1, 1'b1);
        exp_done(1'b1);
        start_xfer(30'h10, 30'h500, 16'd3);
        wait_done("abort_done_timeout", 50);
        chk("abort_err_at_done", 64'(err_o), 64'd1);
        @(negedge clk); #2;
        err_wr_idx = 0;
        chk("abort_err_sticky", 64'(err_o), 64'd1);
        chk("abort_ram0", 64'(mem[30'h500]), 64'(d0));
        chk("abort_no_write", 64'(mem[30'h501]), 64'hDEADBEEF);
        chk("abort_reads", 64'(nrd - rd_base), 64'd2);
        chk("abort_sb_empty", 64'(exp_q.size()), 64'd0);
        exp_done(1'b0);
        start_xfer(30'h0, 30'h0, 16'd0);
        #2;
        chk("abort_err_cleared", 64'(err_o), 64'd0);
        @(negedge clk);

        // Timeout with a silent slave
        no_ack = 1'b1; stb_cnt = 0;
        exp_done(1'b1);
        start_xfer(30'h20, 30'h800, 16'd1);
        wait_done("timeout_done_timeout", 50);
        chk("timeout_err", 64'(err_o), 64'd1);
        @(negedge clk); #2;
        no_ack = 1'b0;
        chk("timeout_stb_cycles", 64'(stb_cnt), 64'(TO + 1));
        chk("timeout_cyc_low", 64'(cyc_o), 64'd0);

        // Address wrap, with start pulses during the transfer and in DONE
        mem[30'h3FFFFFFF] = 32'h5A5A5A5A;
        wait_cyc = 1; stb_cnt = 0;
        exp_rd(30'h3FFFFFFF); exp_wr(30'h600, 32'h5A5A5A5A, 1'b0);
        exp_rd(30'h0);        exp_wr(30'h601, 32'h11111111, 1'b0);
        exp_done(1'b0);
        start_xfer(30'h3FFFFFFF, 30'h600, 16'd2);
        @(negedge clk); @(negedge clk);
        start_i = 1'b1; src_i = 30'h123; dst_i = 30'h124; len_i = 16'd5;
        @(negedge clk);
        start_i = 1'b0;
        wait_done("wrap_done_timeout", 60);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        #2;
        chk("wrap_start_in_done_ignored", 64'(cyc_o), 64'd0);
        repeat (3) @(negedge clk);
        #2;
        chk("wrap_stb_cycles", 64'(stb_cnt), 64'd8);
        chk("wrap_ram0", 64'(mem[30'h600]), 64'h5A5A5A5A);
        chk("wrap_ram1", 64'(mem[30'h601]), 64'h11111111);
        chk("wrap_sb_empty", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset during a write wait
        mem[30'h700] = 32'hCAFEF00D;
        wait_cyc = 6;
        exp_rd(30'h0);
        start_xfer(30'h0, 30'h700, 16'd2);
        for (int i = 0; i < 40 && !we_o; i++) begin
            @(negedge clk); #2;
        end
        chk("rst_mid_in_wr", 64'(we_o), 64'd1);
        #1 rst_ni = 1'b0;
        #1;
        chk("rst_mid_cyc", 64'(cyc_o), 64'd0);
        chk("rst_mid_stb", 64'(stb_o), 64'd0);
        chk("rst_mid_we", 64'(we_o), 64'd0);
        chk("rst_mid_busy", 64'(busy_o), 64'd0);
        chk("rst_mid_adr", 64'(adr_o), 64'd0);
        chk("rst_mid_dat", 64'(dat_o), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_mid_idle_cyc", 64'(cyc_o), 64'd0);
        chk("rst_mid_idle_done", 64'(done_o), 64'd0);
        chk("rst_mid_no_write", 64'(mem[30'h700]), 64'hCAFEF00D);
        wait_cyc = 1;
        exp_rd(30'h1); exp_wr(30'h710, 32'h22222222, 1'b0); exp_done(1'b0);
        start_xfer(30'h1, 30'h710, 16'd1);
        wait_done("rst_copy_done_timeout", 40);
        @(negedge clk); #2;
        chk("rst_copy_ram", 64'(mem[30'h710]), 64'h22222222);
        chk("rst_copy_err", 64'(err_o), 64'd0);
        chk("rst_copy_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
